spi_rx_slave: RTL

//  - SPI slave receiver; the far end of the team's 10-bit SPI master link (CS active-low, SCLK idle low, MSB first, data sampled on SCLK rise).
//  - Oversamples SCLK/CS/SDI in the system clock domain and shifts in DATA_W bits per CS-low frame.
//  - Presents each complete word with a one-cycle valid strobe and flags malformed frames.
//  - Sits on the frame/register board side, feeding received words to local register logic.

---
 rtl/spi_rx_pkg.sv | 29 ++
 rtl/spi_rx_sync.sv | 39 +++
 rtl/spi_rx_slave.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI slave receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_LONG    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int SYNC_DEPTH = 2;
  // Cycles after reset before the synced CS level reflects the pin again.
  localparam int SETTLE_CYC = SYNC_DEPTH + 1;

  // Verdict for a frame closed by CS rise, given the number of SCLK rises seen.
  function automatic logic [1:0] frame_code(input int unsigned cnt, input int unsigned width);
    if (cnt == width) begin
      return ERR_NONE;
    end else if (cnt < width) begin
      return ERR_SHORT;
    end
    return ERR_LONG;
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// One async input: 2-flop synchronizer, delay flop, registered level and edge strobes.
// Level and strobes lag the pin by 3 clk edges and are mutually aligned; no backpressure.
module spi_rx_sync
  import spi_rx_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  dly_q;
  logic                  s;

  assign s = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
      dly_q  <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      dly_q  <= s;
      rise   <= s & ~dly_q;
      fall   <= ~s & dly_q;
    end
  end

  // The delay flop holds the same sample the strobes were computed from.
  assign lvl = dly_q;

endmodule

// File: rtl/spi_rx_slave.sv
// SPI slave receiver (CS low frames, SCLK rise sampling, MSB first); rx_valid/rx_err strobes 4 clk edges
// after the edge that first samples CS high; no backpressure. Define SPI_RX_TIMEOUT_EN for the stalled-SCLK abort.
module spi_rx_slave
  import spi_rx_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_sdi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic [1:0]        rx_err_code,
  output logic              busy
);

  localparam int CNT_W    = $clog2(DATA_W + 2);
  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_rx_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .din  (spi_clk),
    .lvl  (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_rx_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .reset(reset),
    .din  (spi_cs_n),
    .lvl  (cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_rx_sync #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk  (clk),
    .reset(reset),
    .din  (spi_sdi),
    .lvl  (sdi_s),
    .rise (sdi_rise),
    .fall (sdi_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_lvl, sclk_fall, sdi_rise, sdi_fall};

  state_t              state;
  logic [DATA_W-1:0]   shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                armed;
  logic                fin_vld;
  logic                fin_err;
  logic [1:0]          fin_code;
  logic [DATA_W-1:0]   fin_dat;
  logic [1:0]          end_code;

  assign end_code = frame_code(32'(bit_cnt), DATA_W);

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYC;
`endif

  // The sync flops restart from their reset values, so the CS level is only trusted
  // once the pipeline has refilled; a frame already under way then lands in WAIT_IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      armed      <= 1'b0;
      fin_vld    <= 1'b0;
      fin_err    <= 1'b0;
      fin_code   <= ERR_NONE;
      fin_dat    <= '0;
`ifdef SPI_RX_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      fin_vld  <= 1'b0;
      fin_err  <= 1'b0;
      fin_code <= ERR_NONE;
      if (settle_cnt != SETTLE_W'(SETTLE_CYC)) begin
        settle_cnt <= settle_cnt + SETTLE_W'(1);
      end else if (!armed) begin
        armed <= 1'b1;
        state <= cs_lvl ? IDLE : WAIT_IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              shreg   <= '0;
              bit_cnt <= '0;
              state   <= RECV;
`ifdef SPI_RX_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
          RECV: begin
            // CS rise takes priority; a coincident SCLK rise is not counted.
            if (cs_rise) begin
              state <= IDLE;
              if (end_code == ERR_NONE) begin
                fin_vld <= 1'b1;
                fin_dat <= shreg;
              end else begin
                fin_err  <= 1'b1;
                fin_code <= end_code;
              end
            end else if (sclk_rise) begin
              shreg <= {shreg[DATA_W-2:0], sdi_s};
              if (bit_cnt != CNT_W'(DATA_W + 1)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
`ifdef SPI_RX_TIMEOUT_EN
              tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
              fin_err  <= 1'b1;
              fin_code <= ERR_TIMEOUT;
              state    <= WAIT_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
            end
          end
          WAIT_IDLE: begin
            if (cs_lvl) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= ERR_NONE;
    end else begin
      rx_valid    <= fin_vld;
      rx_err      <= fin_err;
      rx_err_code <= fin_code;
      if (fin_vld) begin
        rx_data <= fin_dat;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
